mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 8-bit program/data memory between two requesters.
//  Requester 0 is the core datapath: fetch and load/store, driven by the core controller.
//  Requester 1 is the boot/debug program loader.
//  Sits between the requesters and the memory block. Owns its address, write-data,
//  mem_read and mem_write pins, and sequences multi-cycle accesses with a latency counter.
// PARAMETERS
//  ADDR_WIDTH   13  memory address width (matches PC/TR width)
//  DATA_WIDTH   8   memory word width
//  MEM_LATENCY  2   cycles mem_read/mem_write is held per access; legal range 1..15
// PORTS
//  clk          in   1           system clock, all state on rising edge
//  rst          in   1           synchronous, active-high reset
//  core_req     in   1           core access request, held high until core_ack
//  core_we      in   1           1 = write, 0 = read
//  core_addr    in   ADDR_WIDTH  core address
//  core_wdata   in   DATA_WIDTH  core write data
//  core_ack     out  1           1-cycle completion pulse to core
//  core_rdata   out  DATA_WIDTH  read data, valid in core_ack cycle
//  ldr_req      in   1           loader request; same rules as core_*
//  ldr_we       in   1           loader write enable
//  ldr_addr     in   ADDR_WIDTH  loader address
//  ldr_wdata    in   DATA_WIDTH  loader write data
//  ldr_ack      out  1           1-cycle completion pulse to loader
//  ldr_rdata    out  DATA_WIDTH  read data, valid in ldr_ack cycle
//  mem_address  out  ADDR_WIDTH  address to memory
//  mem_wdata    out  DATA_WIDTH  write data to memory
//  mem_read     out  1           memory read strobe
//  mem_write    out  1           memory write strobe
//  mem_rdata    in   DATA_WIDTH  memory read data
//  busy         out  1           high whenever state != IDLE
// BEHAVIOUR
//  - Reset values:
//      state = IDLE, last_grant = LDR (so the core wins the first tie), all acks = 0,
//      mem_read = mem_write = 0, mem_address = mem_wdata = 0,
//      core_rdata = ldr_rdata = 0, latency counter = 0, busy = 0.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE, arbitration:
//      * Only one req high: that requester is granted.
//      * Both high: grant the requester != last_grant (round robin); update last_grant.
//      * On grant: register addr, wdata, we and owner id; clear counter; go to ACCESS.
//      * No req: stay in IDLE.
//  - ACCESS:
//      * mem_address and mem_wdata are driven from the latched registers.
//      * mem_read = ~we and mem_write = we, both registered and high for exactly
//        MEM_LATENCY cycles.
//      * The counter increments each cycle. When count == MEM_LATENCY-1: on a read,
//        capture mem_rdata into the owner's rdata register; go to DONE.
//  - DONE:
//      * Strobes are low.
//      * The owner's ack is high for exactly 1 cycle; the other ack stays 0.
//      * Go to IDLE.
//  - Latency: req first seen high in IDLE at edge N -> ack high in cycle N+MEM_LATENCY+1.
//    Minimum spacing between back-to-back grants is MEM_LATENCY+2 cycles.
//  - Requesters drop req in the cycle after ack. A req still high in IDLE after an
//    ack is treated as a new request.
//  - req deasserted mid-access: the access completes and the ack still pulses.
//    Address/data changes mid-access are ignored (latched at grant).
//  - Write access: rdata registers keep their previous values.
//  - Reset asserted in ACCESS or DONE: on the next edge all outputs return to their
//    reset values. No ack is issued, and the aborted access is not retried.
//  - Strobe invariant: mem_read and mem_write are never both high.
//  - Strobes are never high outside ACCESS.
// STRUCTURE
//  - Package mem_arb_pkg:
//      typedef enum {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
//      typedef enum {REQ_CORE, REQ_LDR} req_id_t;
//      localparam LAT_CNT_WIDTH = 4.
//  - One sub-module, latency_counter: 4-bit, sync clear and enable, terminal-count
//    output at MEM_LATENCY-1.
//  - Arbitration logic and the FSM stay in this file.
// TESTING
//  1. Core read, MEM_LATENCY=2: core_req=1, core_addr=0x0005, mem holds 0xA7 at 5
//     -> mem_read high 2 cycles with mem_address=0x0005; core_ack in cycle 3 with
//     core_rdata=0xA7; ldr_ack=0.
//  2. Loader write: ldr_we=1, ldr_addr=0x1FFF, ldr_wdata=0x3C -> mem_write high
//     2 cycles at 0x1FFF; ldr_ack pulses; subsequent core read of 0x1FFF returns 0x3C.
//  3. Both requests held from reset -> grants alternate core, ldr, core, ldr; each
//     ack spaced 4 cycles apart; no requester is starved.
//  4. Assert rst in the 2nd ACCESS cycle of a core write -> next cycle mem_write=0,
//     busy=0, no core_ack; after reset the core's held req is re-granted.
//  5. MEM_LATENCY=1, core_req dropped the cycle after grant and core_addr changed to
//     0x0100 -> access uses the original address; core_ack still pulses once.
//  6. Assertions throughout: never (mem_read && mem_write); never (core_ack && ldr_ack);
//     acks are exactly 1 cycle wide.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester ids and
// the width of the access latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        REQ_CORE,
        REQ_LDR
    } req_id_t;

    localparam int LAT_CNT_WIDTH = 4;

    function automatic req_id_t other_requester(input req_id_t id);
        return (id == REQ_CORE) ? REQ_LDR : REQ_CORE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_latency_counter.sv
// Counts the cycles of one memory access and flags the last one
// (count == MEM_LATENCY-1) so the arbiter can leave ACCESS.
module latency_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [LAT_CNT_WIDTH-1:0] TC_VALUE = LAT_CNT_WIDTH'(MEM_LATENCY - 1);

    logic [LAT_CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TC_VALUE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port program/data memory between
// the core datapath and the boot/debug loader, with registered strobes.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_ack,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    arb_state_t state, state_next;
    req_id_t    last_grant, last_grant_next;
    req_id_t    owner, owner_next;
    req_id_t    grant_id;
    logic       grant_valid;
    logic       we_q, we_next;
    logic       lat_done;

    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] core_rdata_next, ldr_rdata_next;
    logic                  mem_read_next, mem_write_next;
    logic                  core_ack_next, ldr_ack_next;

    latency_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_latency_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ARB_ACCESS),
        .enable  (state == ARB_ACCESS),
        .terminal(lat_done)
    );

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_valid = core_req | ldr_req;
        if (core_req && ldr_req) begin
            grant_id = other_requester(last_grant);
        end else if (core_req) begin
            grant_id = REQ_CORE;
        end else begin
            grant_id = REQ_LDR;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        owner_next      = owner;
        we_next         = we_q;
        addr_next       = mem_address;
        wdata_next      = mem_wdata;
        core_rdata_next = core_rdata;
        ldr_rdata_next  = ldr_rdata;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        core_ack_next   = 1'b0;
        ldr_ack_next    = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_next      = ARB_ACCESS;
                    last_grant_next = grant_id;
                    owner_next      = grant_id;
                    if (grant_id == REQ_CORE) begin
                        we_next    = core_we;
                        addr_next  = core_addr;
                        wdata_next = core_wdata;
                    end else begin
                        we_next    = ldr_we;
                        addr_next  = ldr_addr;
                        wdata_next = ldr_wdata;
                    end
                    mem_read_next  = ~we_next;
                    mem_write_next = we_next;
                end
            end

            // Strobes stay up until the final access cycle, where read data is captured.
            ARB_ACCESS: begin
                if (lat_done) begin
                    state_next = ARB_DONE;
                    if (!we_q) begin
                        if (owner == REQ_CORE) begin
                            core_rdata_next = mem_rdata;
                        end else begin
                            ldr_rdata_next = mem_rdata;
                        end
                    end
                    core_ack_next = (owner == REQ_CORE);
                    ldr_ack_next  = (owner == REQ_LDR);
                end else begin
                    mem_read_next  = ~we_q;
                    mem_write_next = we_q;
                end
            end

            ARB_DONE: begin
                state_next = ARB_IDLE;
            end

            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            last_grant  <= REQ_LDR;
            owner       <= REQ_CORE;
            we_q        <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            core_ack    <= 1'b0;
            ldr_ack     <= 1'b0;
            core_rdata  <= '0;
            ldr_rdata   <= '0;
        end else begin
            state       <= state_next;
            last_grant  <= last_grant_next;
            owner       <= owner_next;
            we_q        <= we_next;
            mem_address <= addr_next;
            mem_wdata   <= wdata_next;
            mem_read    <= mem_read_next;
            mem_write   <= mem_write_next;
            core_ack    <= core_ack_next;
            ldr_ack     <= ldr_ack_next;
            core_rdata  <= core_rdata_next;
            ldr_rdata   <= ldr_rdata_next;
        end
    end

    assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at MEM_LATENCY=2 and one
// at MEM_LATENCY=1, sharing a behavioural memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mem_load;
    int   cyc = 0;

    logic        core_req, core_we, core_ack, ldr_req, ldr_we, ldr_ack;
    logic [12:0] core_addr, ldr_addr, mem_address;
    logic [7:0]  core_wdata, core_rdata, ldr_wdata, ldr_rdata, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    logic        u1_core_req, u1_core_we, u1_core_ack, u1_ldr_req, u1_ldr_we, u1_ldr_ack;
    logic [12:0] u1_core_addr, u1_ldr_addr, u1_mem_address;
    logic [7:0]  u1_core_wdata, u1_core_rdata, u1_ldr_wdata, u1_ldr_rdata;
    logic [7:0]  u1_mem_wdata, u1_mem_rdata;
    logic        u1_mem_read, u1_mem_write, u1_busy;

    logic prev_core_ack, prev_ldr_ack, prev_u1_core_ack, prev_u1_ldr_ack;

    typedef struct {
        bit         inst;
        bit         is_ldr;
        int         cycle;
        bit         check_data;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    mem_port_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .MEM_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .MEM_LATENCY(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .core_req(u1_core_req), .core_we(u1_core_we), .core_addr(u1_core_addr),
        .core_wdata(u1_core_wdata), .core_ack(u1_core_ack), .core_rdata(u1_core_rdata),
        .ldr_req(u1_ldr_req), .ldr_we(u1_ldr_we), .ldr_addr(u1_ldr_addr),
        .ldr_wdata(u1_ldr_wdata), .ldr_ack(u1_ldr_ack), .ldr_rdata(u1_ldr_rdata),
        .mem_address(u1_mem_address), .mem_wdata(u1_mem_wdata), .mem_read(u1_mem_read),
        .mem_write(u1_mem_write), .mem_rdata(u1_mem_rdata), .busy(u1_busy)
    );

    // Asynchronous-read, synchronous-write memory shared by both instances.
    logic [7:0] mem [0:8191];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
            mem[5]      <= 8'hA7;
            mem[13'h100] <= 8'h11;
        end else begin
            if (mem_write) mem[mem_address] <= mem_wdata;
            if (u1_mem_write) mem[u1_mem_address] <= u1_mem_wdata;
        end
    end

    assign mem_rdata    = mem[mem_address];
    assign u1_mem_rdata = mem[u1_mem_address];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic scoreboardPop(input bit inst, input bit is_ldr, input logic [7:0] rdata);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_ack: got ack inst=%0d ldr=%0d at cycle %0d, expected none", inst, is_ldr, cyc);
        end else begin
            e = sb_q.pop_front();
            checkOutput("ack_cycle", 16'(cyc), 16'(e.cycle));
            checkOutput("ack_owner", 16'({inst, is_ldr}), 16'({e.inst, e.is_ldr}));
            if (e.check_data) checkOutput("ack_rdata", 16'(rdata), 16'(e.data));
        end
    endtask

    // Monitor: protocol invariants every cycle, scoreboard compare on every ack.
    initial begin
        prev_core_ack = 1'b0; prev_ldr_ack = 1'b0;
        prev_u1_core_ack = 1'b0; prev_u1_ldr_ack = 1'b0;
        forever begin
            @(negedge clk);
            checkOutput("invariants_lat2",
                16'({mem_read & mem_write, core_ack & ldr_ack, core_ack & prev_core_ack,
                     ldr_ack & prev_ldr_ack, (mem_read | mem_write) & ~busy}), 16'h0);
            checkOutput("invariants_lat1",
                16'({u1_mem_read & u1_mem_write, u1_core_ack & u1_ldr_ack,
                     u1_core_ack & prev_u1_core_ack, u1_ldr_ack & prev_u1_ldr_ack,
                     (u1_mem_read | u1_mem_write) & ~u1_busy}), 16'h0);
            if (core_ack || ldr_ack) scoreboardPop(1'b0, ldr_ack, ldr_ack ? ldr_rdata : core_rdata);
            if (u1_core_ack || u1_ldr_ack) scoreboardPop(1'b1, u1_ldr_ack, u1_ldr_ack ? u1_ldr_rdata : u1_core_rdata);
            prev_core_ack = core_ack; prev_ldr_ack = ldr_ack;
            prev_u1_core_ack = u1_core_ack; prev_u1_ldr_ack = u1_ldr_ack;
        end
    end

    function automatic logic ackOf(input bit inst, input bit is_ldr);
        if (inst) return is_ldr ? u1_ldr_ack : u1_core_ack;
        return is_ldr ? ldr_ack : core_ack;
    endfunction

    function automatic logic [1:0] strobesOf(input bit inst);
        return inst ? {u1_mem_read, u1_mem_write} : {mem_read, mem_write};
    endfunction

    function automatic logic [12:0] addrOf(input bit inst);
        return inst ? u1_mem_address : mem_address;
    endfunction

    task automatic driveReq(input bit inst, input bit is_ldr, input logic req, input logic we,
                            input logic [12:0] addr, input logic [7:0] wdata);
        if (!inst && !is_ldr) begin core_req = req; core_we = we; core_addr = addr; core_wdata = wdata; end
        else if (!inst) begin ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; end
        else if (!is_ldr) begin u1_core_req = req; u1_core_we = we; u1_core_addr = addr; u1_core_wdata = wdata; end
        else begin u1_ldr_req = req; u1_ldr_we = we; u1_ldr_addr = addr; u1_ldr_wdata = wdata; end
    endtask

    // One access from an idle arbiter; expected ack lands MEM_LATENCY+1 cycles after the request.
    task automatic applyStimulus(input bit inst, input bit is_ldr, input logic we, input logic [12:0] addr,
                                 input logic [7:0] wdata, input bit check_data, input logic [7:0] exp_data,
                                 input bit drop_early);
        exp_t e;
        int   lat;
        bit   seen;
        lat = inst ? 1 : 2;
        @(negedge clk);
        driveReq(inst, is_ldr, 1'b1, we, addr, wdata);
        e.inst = inst; e.is_ldr = is_ldr; e.cycle = cyc + 1 + lat;
        e.check_data = check_data; e.data = exp_data;
        sb_q.push_back(e);
        @(negedge clk);
        checkOutput("mem_address", 16'(addrOf(inst)), 16'(addr));
        if (drop_early) driveReq(inst, is_ldr, 1'b0, we, 13'h0100, 8'hEE);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ackOf(inst, is_ldr)) begin
                seen = 1'b1;
                checkOutput("strobes_in_done", 16'(strobesOf(inst)), 16'h0);
            end else begin
                checkOutput("strobes_in_access", 16'(strobesOf(inst)), 16'({~we, we}));
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++;
            $display("[TB] FAIL ack_timeout: got no ack within 20 cycles, expected ack inst=%0d ldr=%0d", inst, is_ldr);
        end
        driveReq(inst, is_ldr, 1'b0, we, addr, wdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        mem_load = 1'b1;
        rst = 1'b1;
        driveReq(1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0);
        driveReq(1'b0, 1'b1, 1'b0, 1'b0, 13'h0, 8'h0);
        driveReq(1'b1, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0);
        driveReq(1'b1, 1'b1, 1'b0, 1'b0, 13'h0, 8'h0);
        repeat (2) @(negedge clk);
        mem_load = 1'b0;

        checkOutput("reset_busy", 16'(busy), 16'h0);
        checkOutput("reset_strobes", 16'({mem_read, mem_write}), 16'h0);
        checkOutput("reset_acks", 16'({core_ack, ldr_ack}), 16'h0);
        checkOutput("reset_mem_address", 16'(mem_address), 16'h0);
        checkOutput("reset_mem_wdata", 16'(mem_wdata), 16'h0);
        checkOutput("reset_rdata", 16'({core_rdata, ldr_rdata}), 16'h0);
        checkOutput("reset_busy_lat1", 16'(u1_busy), 16'h0);
        rst = 1'b0;

        // Core read, loader read, loader write, then core reads back the loader's write.
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h0005, 8'h00, 1'b1, 8'hA7, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0005, 8'h00, 1'b1, 8'hA7, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h1FFF, 8'h3C, 1'b0, 8'h00, 1'b0);
        checkOutput("ldr_rdata_kept_on_write", 16'(ldr_rdata), 16'h00A7);
        checkOutput("core_rdata_kept", 16'(core_rdata), 16'h00A7);
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h1FFF, 8'h00, 1'b1, 8'h3C, 1'b0);

        // Both requesters held through reset: core, ldr, core, ldr, acks 4 cycles apart.
        @(negedge clk);
        rst = 1'b1;
        driveReq(1'b0, 1'b0, 1'b1, 1'b0, 13'h0005, 8'h00);
        driveReq(1'b0, 1'b1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        @(negedge clk);
        checkOutput("reset_busy_held_reqs", 16'(busy), 16'h0);
        checkOutput("reset_core_rdata_cleared", 16'(core_rdata), 16'h0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e.inst = 1'b0; e.is_ldr = k[0]; e.cycle = cyc + 3 + 4 * k;
            e.check_data = 1'b1; e.data = k[0] ? 8'h3C : 8'hA7;
            sb_q.push_back(e);
        end
        repeat (15) @(negedge clk);
        driveReq(1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 8'h00);
        driveReq(1'b0, 1'b1, 1'b0, 1'b0, 13'h0, 8'h00);

        // Reset during the second ACCESS cycle of a core write, then re-grant.
        @(negedge clk);
        driveReq(1'b0, 1'b0, 1'b1, 1'b1, 13'h0042, 8'h55);
        @(negedge clk);
        checkOutput("abort_write_cycle1", 16'(mem_write), 16'h1);
        @(negedge clk);
        checkOutput("abort_write_cycle2", 16'(mem_write), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_strobe_low", 16'(mem_write), 16'h0);
        checkOutput("abort_busy_low", 16'(busy), 16'h0);
        checkOutput("abort_no_ack", 16'(core_ack), 16'h0);
        checkOutput("abort_address_reset", 16'(mem_address), 16'h0);
        rst = 1'b0;
        e.inst = 1'b0; e.is_ldr = 1'b0; e.cycle = cyc + 3; e.check_data = 1'b0; e.data = 8'h00;
        sb_q.push_back(e);
        for (int i = 0; i < 10 && !core_ack; i++) @(negedge clk);
        if (!core_ack) begin
            checks++;
            $display("[TB] FAIL regrant_timeout: got no core_ack after reset, expected re-grant");
        end
        driveReq(1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 13'h0042, 8'h00, 1'b1, 8'h55, 1'b0);

        // MEM_LATENCY=1: req dropped and address changed after grant; original address used.
        applyStimulus(1'b1, 1'b0, 1'b0, 13'h0005, 8'h00, 1'b1, 8'hA7, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 13'h0100, 8'h00, 1'b1, 8'h11, 1'b0);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 16'(sb_q.size()), 16'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
